// File: rtl/stripe_pkg.sv
// Shared types and default widths for the stripe/pattern scroll logic.
package stripe_pkg;

    localparam int unsigned OFFSET_W_DEF = 10;
    localparam int unsigned SPEED_W_DEF  = 4;
    localparam int unsigned PHASE_W      = 3;
    localparam int unsigned HOLD_W       = 8;

    typedef enum logic [PHASE_W-1:0] {
        PH_MANUAL  = 3'd0,
        PH_ACCEL   = 3'd1,
        PH_CRUISE  = 3'd2,
        PH_DECEL   = 3'd3,
        PH_REVERSE = 3'd4
    } phase_e;

endpackage

// File: rtl/frame_edge_det.sv
// Polarity-normalised vsync assertion-edge detector; registered one-cycle frame tick.
module frame_edge_det #(
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic vs_act;
    logic hist_q;
    logic armed_q;
    logic tick_q;

    assign vs_act = VSYNC_ACTIVE_LOW ? ~vsync : vsync;

    // armed_q suppresses a false edge when reset releases in the middle of a pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            hist_q  <= vs_act;
            armed_q <= 1'b1;
            tick_q  <= armed_q & ~hist_q & vs_act;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/stripe_scroll_sched.sv
// Per-frame scroll scheduler: manual or FSM-driven speed/direction, offset updated once per frame.
module stripe_scroll_sched
    import stripe_pkg::*;
#(
    parameter int unsigned OFFSET_W         = OFFSET_W_DEF,
    parameter int unsigned SPEED_W          = SPEED_W_DEF,
    parameter int unsigned MAX_SPEED        = 8,
    parameter int unsigned HOLD_FRAMES      = 60,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vsync,
    input  logic                auto_en,
    input  logic                pause,
    input  logic [SPEED_W-1:0]  man_speed,
    input  logic                man_dir,
    output logic                frame_tick,
    output logic [OFFSET_W-1:0] scroll_x,
    output logic [SPEED_W-1:0]  cur_speed,
    output logic                cur_dir,
    output logic [PHASE_W-1:0]  phase
);

    localparam logic [SPEED_W-1:0] MAX_S     = SPEED_W'(MAX_SPEED);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    logic tick;

    phase_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SPEED_W-1:0]  spd_q, spd_d;
    logic                dir_q, dir_d;
    logic [OFFSET_W-1:0] sx_q, sx_d;

    frame_edge_det #(
        .VSYNC_ACTIVE_LOW(VSYNC_ACTIVE_LOW)
    ) u_edge (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .frame_tick(tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PH_ACCEL;
            phase_q <= PH_MANUAL;
            hold_q  <= '0;
            spd_q   <= '0;
            dir_q   <= 1'b0;
            sx_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            spd_q   <= spd_d;
            dir_q   <= dir_d;
            sx_q    <= sx_d;
        end
    end

    // Speed/direction are resolved first; the offset then moves by the new values.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        spd_d   = spd_q;
        dir_d   = dir_q;
        sx_d    = sx_q;
        if (tick && !pause) begin
            if (!auto_en) begin
                spd_d   = (man_speed > MAX_S) ? MAX_S : man_speed;
                dir_d   = man_dir;
                state_d = PH_ACCEL;
                hold_d  = '0;
                phase_d = PH_MANUAL;
            end else begin
                case (state_q)
                    PH_CRUISE: begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = PH_DECEL;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    PH_DECEL: begin
                        spd_d = (spd_q == '0) ? '0 : spd_q - SPEED_W'(1);
                        if (spd_d == '0) begin
                            state_d = PH_REVERSE;
                        end
                    end
                    PH_REVERSE: begin
                        dir_d   = ~dir_q;
                        spd_d   = '0;
                        state_d = PH_ACCEL;
                    end
                    default: begin
                        // also absorbs an over-range speed inherited from manual mode
                        spd_d = (spd_q >= MAX_S) ? MAX_S : spd_q + SPEED_W'(1);
                        if (spd_d == MAX_S) begin
                            state_d = PH_CRUISE;
                            hold_d  = '0;
                        end
                    end
                endcase
                phase_d = state_d;
            end
            sx_d = dir_d ? sx_q - OFFSET_W'(spd_d) : sx_q + OFFSET_W'(spd_d);
        end
    end

    assign frame_tick = tick;
    assign scroll_x   = sx_q;
    assign cur_speed  = spd_q;
    assign cur_dir    = dir_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_stripe_scroll_sched.sv
// Scoreboard bench: two scheduler instances (different MAX_SPEED/HOLD_FRAMES) against a frame-level model.
module tb_stripe_scroll_sched;

    typedef struct {
        int sx;
        int spd;
        int dir;
        int ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       vs_act;
    logic       vsync;
    logic       auto_en;
    logic       pause;
    logic [3:0] man_speed;
    logic       man_dir;

    logic       o_ft  [2];
    logic [9:0] o_sx  [2];
    logic [3:0] o_spd [2];
    logic       o_dir [2];
    logic [2:0] o_ph  [2];

    bit reset_probe = 1'b0;
    bit done        = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t qa[$];
    exp_t qb[$];

    int m_sx[2], m_spd[2], m_dir[2], m_st[2], m_hold[2], m_ph[2];

    always #5 clk = ~clk;
    assign vsync = ~vs_act;

    stripe_scroll_sched #(
        .OFFSET_W(10), .SPEED_W(4), .MAX_SPEED(8), .HOLD_FRAMES(4), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .vsync(vsync), .auto_en(auto_en), .pause(pause),
        .man_speed(man_speed), .man_dir(man_dir), .frame_tick(o_ft[0]), .scroll_x(o_sx[0]),
        .cur_speed(o_spd[0]), .cur_dir(o_dir[0]), .phase(o_ph[0])
    );

    stripe_scroll_sched #(
        .OFFSET_W(10), .SPEED_W(4), .MAX_SPEED(3), .HOLD_FRAMES(2), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .vsync(vsync), .auto_en(auto_en), .pause(pause),
        .man_speed(man_speed), .man_dir(man_dir), .frame_tick(o_ft[1]), .scroll_x(o_sx[1]),
        .cur_speed(o_spd[1]), .cur_dir(o_dir[1]), .phase(o_ph[1])
    );

    function automatic int max_of(input int i);
        return (i == 0) ? 8 : 3;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Phase codes: 1 accelerate, 2 cruise, 3 decelerate, 4 reverse; 0 while manual.
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sx[i] = 0; m_spd[i] = 0; m_dir[i] = 0;
            m_st[i] = 1; m_hold[i] = 0; m_ph[i] = 0;
        end
    endtask

    task automatic model_frame();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!pause) begin
                if (!auto_en) begin
                    m_spd[i]  = (int'(man_speed) > max_of(i)) ? max_of(i) : int'(man_speed);
                    m_dir[i]  = int'(man_dir);
                    m_st[i]   = 1;
                    m_hold[i] = 0;
                    m_ph[i]   = 0;
                end else begin
                    if (m_st[i] == 1) begin
                        m_spd[i] = m_spd[i] + 1;
                        if (m_spd[i] >= max_of(i)) begin
                            m_spd[i] = max_of(i);
                            m_st[i] = 2;
                            m_hold[i] = 0;
                        end
                    end else if (m_st[i] == 2) begin
                        if (m_hold[i] == hold_of(i) - 1) m_st[i] = 3;
                        else m_hold[i] = m_hold[i] + 1;
                    end else if (m_st[i] == 3) begin
                        if (m_spd[i] > 0) m_spd[i] = m_spd[i] - 1;
                        if (m_spd[i] == 0) m_st[i] = 4;
                    end else begin
                        m_dir[i] = 1 - m_dir[i];
                        m_spd[i] = 0;
                        m_st[i] = 1;
                    end
                    m_ph[i] = m_st[i];
                end
                m_sx[i] = (m_dir[i] != 0) ? (m_sx[i] - m_spd[i] + 1024) % 1024
                                          : (m_sx[i] + m_spd[i]) % 1024;
            end
            e.sx = m_sx[i]; e.spd = m_spd[i]; e.dir = m_dir[i]; e.ph = m_ph[i];
            if (i == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input bit ae, input bit p, input int ms, input bit md, input bit rst_mid);
        auto_en = ae; pause = p; man_speed = 4'(ms); man_dir = md;
        cyc(3);
        vs_act = 1'b1;
        model_frame();
        if (rst_mid) begin
            cyc(4);
            reset = 1'b1;
            cyc(1);
            reset = 1'b0;
            model_reset();
            reset_probe = 1'b1;
            cyc(1);
            reset_probe = 1'b0;
        end else begin
            cyc(6);
        end
        vs_act = 1'b0;
        cyc(3);
    endtask

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", name, i, act, exp);
        end
    endtask

    function automatic int q_size(input int i);
        return (i == 0) ? qa.size() : qb.size();
    endfunction

    // Monitor: the only process that compares and steps the counters.
    initial begin : monitor
        bit   pend[2];
        exp_t e;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (reset_probe) begin
                    chk("rst_scroll_x", i, int'(o_sx[i]), 0);
                    chk("rst_speed", i, int'(o_spd[i]), 0);
                    chk("rst_dir", i, int'(o_dir[i]), 0);
                    chk("rst_phase", i, int'(o_ph[i]), 0);
                    chk("rst_tick", i, int'(o_ft[i]), 0);
                end else if (pend[i]) begin
                    pend[i] = 1'b0;
                    chk("tick_width", i, int'(o_ft[i]), 0);
                    if (i == 0) e = qa.pop_front();
                    else e = qb.pop_front();
                    chk("scroll_x", i, int'(o_sx[i]), e.sx);
                    chk("cur_speed", i, int'(o_spd[i]), e.spd);
                    chk("cur_dir", i, int'(o_dir[i]), e.dir);
                    chk("phase", i, int'(o_ph[i]), e.ph);
                end else if (o_ft[i]) begin
                    if (q_size(i) == 0) chk("unexpected_tick", i, 1, 0);
                    else pend[i] = 1'b1;
                end
            end
            if (done) begin
                for (int i = 0; i < 2; i++) chk("missing_ticks", i, q_size(i), 0);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; vs_act = 1'b0; auto_en = 1'b0; pause = 1'b0;
        man_speed = 4'd0; man_dir = 1'b0;
        model_reset();
        cyc(3);
        reset = 1'b0;
        reset_probe = 1'b1;
        cyc(1);
        reset_probe = 1'b0;
        cyc(2);

        // manual speed 5 forward: A 5,10,15; B clamps to 3
        for (int k = 0; k < 3; k++) frame(1'b0, 1'b0, 5, 1'b0, 1'b0);
        // walk A down to 3, then clamp 15->8 backwards to wrap at 1019
        frame(1'b0, 1'b0, 12, 1'b1, 1'b0);
        frame(1'b0, 1'b0, 4, 1'b1, 1'b0);
        frame(1'b0, 1'b0, 15, 1'b1, 1'b0);
        // manual 7, then switch to auto: B lands directly in cruise at 3
        frame(1'b0, 1'b0, 7, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
        // reset in the middle of a vsync pulse; no extra tick may follow
        frame(1'b1, 1'b0, 0, 1'b0, 1'b1);
        // full auto cycle from reset, into cruise, pause 4 frames, resume
        for (int k = 0; k < 12; k++) frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) frame(1'b1, 1'b1, 0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
        // randomised mode/pause/manual mix
        for (int k = 0; k < 40; k++) begin
            frame(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int k = 0; k < 24; k++) frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cyc(5);
        done = 1'b1;
    end

endmodule
